// File: rtl/des_kernel_driver.sv
// -----------------------------------------------------------------------------
// des_kernel_driver
//
// Initiator for the HLS ap_ctrl_hs / ap_ctrl_chain block-level handshake.
// It takes one block per request, starts the kernel, captures ap_return on
// ap_done and hands the result back over a valid/ready response channel. It
// also keeps profiling state: a per-transaction latency counter, saturating
// good/timeout transaction counters, and a start-to-done timeout.
//
// Ports
//   ap_clk, ap_rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready/req_data   request channel (one DATA_W block)
//   k_ap_start/k_ap_ready/k_ap_done/k_ap_idle/k_ap_continue
//                               kernel block-level control
//   k_arg                       registered kernel argument
//   k_ap_return                 kernel result
//   rsp_valid/rsp_ready/rsp_data/rsp_timeout
//                               response channel; rsp_data is 0 on timeout
//   busy                        driver is not idle
//   txn_count, timeout_count    saturating completion counters
//   last_latency                start-to-done cycles of the last good response
// -----------------------------------------------------------------------------
module des_kernel_driver #(
  parameter int DATA_W      = 64,
  parameter int RET_W       = 64,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  output logic              k_ap_start,
  input  logic              k_ap_ready,
  input  logic              k_ap_done,
  input  logic              k_ap_idle,
  output logic              k_ap_continue,
  output logic [DATA_W-1:0] k_arg,
  input  logic [RET_W-1:0]  k_ap_return,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RET_W-1:0]  rsp_data,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [CNT_W-1:0]  txn_count,
  output logic [CNT_W-1:0]  timeout_count,
  output logic [CNT_W-1:0]  last_latency
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_DONE = 3'd2;
  localparam logic [2:0] S_RESP      = 3'd3;
  localparam logic [2:0] S_FLUSH     = 3'd4;

  localparam bit              TO_EN    = (TIMEOUT_CYC > 0);
  localparam logic [CNT_W-1:0] TO_LIMIT = TO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] lat_cnt;
  logic             in_run;
  logic             done_hit;
  logic             timeout_hit;
  logic             req_fire;
  logic             rsp_fire;

  // Control outputs decode straight from the state register, so an async
  // reset forces them low without waiting for a clock edge.
  assign req_ready     = ap_rst_n && (state == S_IDLE);
  assign k_ap_start    = (state == S_START);
  assign k_ap_continue = (state == S_START) || (state == S_WAIT_DONE) ||
                         (state == S_FLUSH);
  assign rsp_valid     = (state == S_RESP);
  assign busy          = (state != S_IDLE);

  assign req_fire = req_valid && req_ready;
  assign rsp_fire = rsp_valid && rsp_ready;
  assign in_run   = (state == S_START) || (state == S_WAIT_DONE);

  // A completion only counts once the kernel has also taken its inputs;
  // in START that means ready and done in the same cycle.
  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise the
    // paths that do not assign it would infer a latch.
    done_hit = 1'b0;
    case (state)
      S_START:     done_hit = k_ap_ready && k_ap_done;
      S_WAIT_DONE: done_hit = k_ap_done;
      default:     done_hit = 1'b0;
    endcase
  end

  // A done arriving in the limit cycle wins over the timeout.
  assign timeout_hit = TO_EN && in_run && (lat_cnt == TO_LIMIT) && !done_hit;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (req_fire) state_nxt = S_START;
      S_START: begin
        if (done_hit || timeout_hit) state_nxt = S_RESP;
        else if (k_ap_ready)         state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (done_hit || timeout_hit) state_nxt = S_RESP;
      // A timed-out kernel is still running; drain it before the next start.
      S_RESP:      if (rsp_ready) state_nxt = rsp_timeout ? S_FLUSH : S_IDLE;
      S_FLUSH:     if (k_ap_idle) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state         <= S_IDLE;
      lat_cnt       <= '0;
      k_arg         <= '0;
      rsp_data      <= '0;
      rsp_timeout   <= 1'b0;
      txn_count     <= '0;
      timeout_count <= '0;
      last_latency  <= '0;
    end else begin
      state <= state_nxt;

      if (req_fire) begin
        k_arg   <= req_data;
        lat_cnt <= '0;
      end else if (in_run && (lat_cnt != '1)) begin
        // Still counting in the done cycle, so RESP holds start-to-done
        // inclusive (a one-cycle kernel reads 1).
        lat_cnt <= lat_cnt + 1'b1;
      end

      if (done_hit) begin
        rsp_data    <= k_ap_return;
        rsp_timeout <= 1'b0;
      end else if (timeout_hit) begin
        rsp_data    <= '0;
        rsp_timeout <= 1'b1;
      end

      if (rsp_fire) begin
        rsp_timeout <= 1'b0;
        if (rsp_timeout) begin
          if (timeout_count != '1) timeout_count <= timeout_count + 1'b1;
        end else begin
          if (txn_count != '1) txn_count <= txn_count + 1'b1;
          last_latency <= lat_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_des_kernel_driver.sv
// -----------------------------------------------------------------------------
// tb_des_kernel_driver
//
// Directed bench for des_kernel_driver (TIMEOUT_CYC = 16). A small kernel
// model raises ap_ready / ap_done at configurable cycle offsets counted from
// the first ap_start cycle; all expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_des_kernel_driver;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_data;
  logic        k_ap_start;
  logic        k_ap_ready;
  logic        k_ap_done;
  logic        k_ap_idle;
  logic        k_ap_continue;
  logic [63:0] k_arg;
  logic [63:0] k_ap_return;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_timeout;
  logic        busy;
  logic [31:0] txn_count;
  logic [31:0] timeout_count;
  logic [31:0] last_latency;

  int n_checks = 0;
  int n_errors = 0;

  // Kernel model configuration
  int          kcfg_rdy  = 1;
  int          kcfg_done = 1;
  bit          kcfg_swap = 1'b0;
  logic [63:0] kcfg_ret  = '0;
  bit          kactive;
  int          kcnt;

  des_kernel_driver #(
    .DATA_W      (64),
    .RET_W       (64),
    .CNT_W       (32),
    .TIMEOUT_CYC (16)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_data      (req_data),
    .k_ap_start    (k_ap_start),
    .k_ap_ready    (k_ap_ready),
    .k_ap_done     (k_ap_done),
    .k_ap_idle     (k_ap_idle),
    .k_ap_continue (k_ap_continue),
    .k_arg         (k_arg),
    .k_ap_return   (k_ap_return),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_timeout   (rsp_timeout),
    .busy          (busy),
    .txn_count     (txn_count),
    .timeout_count (timeout_count),
    .last_latency  (last_latency)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after the edge; the
  // kernel model updates at 1 time unit, so its outputs are settled by then.
  task automatic tick();
    @(posedge ap_clk);
    #2;
  endtask

  // Kernel model: cycle 1 is the first cycle ap_start is seen high.
  initial begin
    k_ap_ready  = 1'b0;
    k_ap_done   = 1'b0;
    k_ap_idle   = 1'b1;
    k_ap_return = '0;
    kactive     = 1'b0;
    kcnt        = 0;
    forever begin
      @(posedge ap_clk);
      #1;
      if (!ap_rst_n) begin
        kactive = 1'b0;
        kcnt    = 0;
      end else if (!kactive && k_ap_start) begin
        kactive = 1'b1;
        kcnt    = 1;
      end else if (kactive) begin
        kcnt++;
      end
      k_ap_ready  = kactive && k_ap_start && (kcnt == kcfg_rdy);
      k_ap_done   = kactive && (kcnt == kcfg_done);
      k_ap_idle   = !kactive;
      k_ap_return = !k_ap_done ? 64'hDEAD_BEEF_DEAD_BEEF :
                    kcfg_swap  ? {k_arg[31:0], k_arg[63:32]} : kcfg_ret;
      if (k_ap_done) kactive = 1'b0;
    end
  end

  // One complete transaction from an IDLE cycle; optional response back-pressure.
  task automatic do_txn(input string tag, input logic [63:0] data, input logic [63:0] exp_ret,
                        input int exp_lat, input int exp_starts, input int hold, input int exp_txn);
    int n;
    int starts;
    int arg_bad;
    int hold_bad;
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    req_data  = data;
    check({tag, " req_ready"}, 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    req_data  = '0;
    n = 0; starts = 0; arg_bad = 0;
    while (!rsp_valid && n < 100) begin
      if (k_ap_start) starts++;
      if (k_arg !== data) arg_bad++;
      tick();
      n++;
    end
    check({tag, " run cycles"}, 64'(n), 64'(exp_lat));
    check({tag, " start cycles"}, 64'(starts), 64'(exp_starts));
    check({tag, " k_arg stable"}, 64'(arg_bad), 64'd0);
    check({tag, " rsp_data"}, rsp_data, exp_ret);
    check({tag, " rsp_timeout"}, 64'(rsp_timeout), 64'd0);
    check({tag, " continue in RESP"}, 64'(k_ap_continue), 64'd0);
    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      if (!rsp_valid || rsp_data !== exp_ret || k_ap_continue || req_ready) hold_bad++;
      tick();
    end
    if (hold > 0) begin
      check({tag, " hold stable"}, 64'(hold_bad), 64'd0);
      check({tag, " valid after hold"}, 64'(rsp_valid), 64'd1);
    end
    rsp_ready = 1'b1;
    tick();
    check({tag, " rsp_valid cleared"}, 64'(rsp_valid), 64'd0);
    check({tag, " txn_count"}, 64'(txn_count), 64'(exp_txn));
    check({tag, " last_latency"}, 64'(last_latency), 64'(exp_lat));
    check({tag, " idle req_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] bb_in  [4];
    logic [63:0] bb_exp [4];
    int          bb_t   [4];
    int          n;
    int          bad;
    int          got;
    int          idx;
    bit          accept;

    ap_rst_n  = 1'b0;
    req_valid = 1'b0;
    req_data  = '0;
    rsp_ready = 1'b1;
    #1;
    check("rst req_ready low", 64'(req_ready), 64'd0);
    repeat (3) tick();
    ap_rst_n = 1'b1;
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst k_ap_start", 64'(k_ap_start), 64'd0);
    check("rst k_ap_continue", 64'(k_ap_continue), 64'd0);
    check("rst k_arg", k_arg, 64'd0);
    check("rst rsp_data", rsp_data, 64'd0);
    check("rst txn_count", 64'(txn_count), 64'd0);
    check("rst timeout_count", 64'(timeout_count), 64'd0);
    check("rst last_latency", 64'(last_latency), 64'd0);
    check("rst req_ready", 64'(req_ready), 64'd1);
    tick();

    // Single request: ready in cycle 1, done in cycle 5.
    kcfg_rdy = 1; kcfg_done = 5; kcfg_swap = 1'b0; kcfg_ret = 64'h85E8_1354_0F0A_B405;
    do_txn("single", 64'h0123_4567_89AB_CDEF, 64'h85E8_1354_0F0A_B405, 5, 1, 0, 1);

    // Ready held off 3 cycles, then ready and done together.
    kcfg_rdy = 4; kcfg_done = 4; kcfg_ret = 64'h1122_3344_5566_7788;
    do_txn("late_ready", 64'hA5A5_5A5A_0F0F_F0F0, 64'h1122_3344_5566_7788, 4, 4, 0, 2);

    // Response back-pressure for 10 cycles, then an immediate follow-up request.
    kcfg_rdy = 1; kcfg_done = 2; kcfg_ret = 64'hCAFE_F00D_1234_5678;
    do_txn("backpressure", 64'h0000_1111_2222_3333, 64'hCAFE_F00D_1234_5678, 2, 1, 10, 3);
    kcfg_ret = 64'h0BAD_C0DE_0000_0001;
    do_txn("followup", 64'h4444_5555_6666_7777, 64'h0BAD_C0DE_0000_0001, 2, 1, 0, 4);

    // Timeout: done arrives only in kernel cycle 22, long after the 16-cycle limit.
    kcfg_rdy = 1; kcfg_done = 22; kcfg_ret = 64'h7777_7777_7777_7777;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_data  = 64'hFEED_FACE_0000_0016;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    check("to run cycles", 64'(n), 64'd16);
    check("to rsp_timeout", 64'(rsp_timeout), 64'd1);
    check("to rsp_data", rsp_data, 64'd0);
    check("to k_ap_start", 64'(k_ap_start), 64'd0);
    tick();
    check("to timeout_count", 64'(timeout_count), 64'd1);
    check("to txn_count", 64'(txn_count), 64'd4);
    check("to last_latency", 64'(last_latency), 64'd2);
    check("to rsp_timeout cleared", 64'(rsp_timeout), 64'd0);
    check("to rsp_valid cleared", 64'(rsp_valid), 64'd0);
    check("flush busy", 64'(busy), 64'd1);
    n = 0; bad = 0;
    while (!req_ready && n < 50) begin
      if (rsp_valid || !k_ap_continue || k_ap_start) bad++;
      tick();
      n++;
    end
    check("flush cycles", 64'(n), 64'd6);
    check("flush late done ignored", 64'(bad), 64'd0);
    check("flush rsp_data kept", rsp_data, 64'd0);
    check("flush txn_count", 64'(txn_count), 64'd4);

    // Four back-to-back requests through a 3-cycle kernel returning swapped halves.
    kcfg_rdy = 1; kcfg_done = 3; kcfg_swap = 1'b1;
    bb_in[0]  = 64'h0000_0001_0000_0010; bb_exp[0] = 64'h0000_0010_0000_0001;
    bb_in[1]  = 64'h0000_0002_0000_0020; bb_exp[1] = 64'h0000_0020_0000_0002;
    bb_in[2]  = 64'h0000_0003_0000_0030; bb_exp[2] = 64'h0000_0030_0000_0003;
    bb_in[3]  = 64'h0000_0004_0000_0040; bb_exp[3] = 64'h0000_0040_0000_0004;
    rsp_ready = 1'b1;
    idx = 0; got = 0;
    req_valid = 1'b1;
    req_data  = bb_in[0];
    for (int c = 0; c < 60 && got < 4; c++) begin
      if (rsp_valid) begin
        check($sformatf("b2b rsp_data %0d", got), rsp_data, bb_exp[got]);
        bb_t[got] = c;
        got++;
      end
      accept = req_valid && req_ready;
      tick();
      if (accept) begin
        idx++;
        if (idx < 4) req_data = bb_in[idx];
        else begin
          req_valid = 1'b0;
          req_data  = '0;
        end
      end
    end
    check("b2b responses", 64'(got), 64'd4);
    for (int i = 1; i < got; i++)
      check($sformatf("b2b spacing %0d", i), 64'(bb_t[i] - bb_t[i-1]), 64'd5);
    check("b2b txn_count", 64'(txn_count), 64'd8);
    check("b2b last_latency", 64'(last_latency), 64'd3);
    kcfg_swap = 1'b0;

    // Reset while in WAIT_DONE.
    kcfg_rdy = 1; kcfg_done = 5; kcfg_ret = 64'h5555_AAAA_5555_AAAA;
    req_valid = 1'b1;
    req_data  = 64'h1234_0000_0000_4321;
    tick();
    req_valid = 1'b0;
    tick();
    check("pre-rst in WAIT_DONE", 64'({busy, k_ap_start, k_ap_continue}), 64'b101);
    ap_rst_n = 1'b0;
    #1;
    check("arst busy", 64'(busy), 64'd0);
    check("arst k_ap_start", 64'(k_ap_start), 64'd0);
    check("arst k_ap_continue", 64'(k_ap_continue), 64'd0);
    check("arst req_ready", 64'(req_ready), 64'd0);
    check("arst rsp_valid", 64'(rsp_valid), 64'd0);
    check("arst k_arg", k_arg, 64'd0);
    check("arst rsp_data", rsp_data, 64'd0);
    check("arst txn_count", 64'(txn_count), 64'd0);
    check("arst timeout_count", 64'(timeout_count), 64'd0);
    check("arst last_latency", 64'(last_latency), 64'd0);
    tick();
    tick();
    ap_rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid || busy) bad++;
      tick();
    end
    check("post-rst no response", 64'(bad), 64'd0);
    kcfg_rdy = 1; kcfg_done = 3; kcfg_ret = 64'h0F1E_2D3C_4B5A_6978;
    do_txn("post_rst", 64'h8877_6655_4433_2211, 64'h0F1E_2D3C_4B5A_6978, 3, 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
